// File: rtl/fft_pkg.sv
// Shared constants and types for the FFT frame sequencer.
// Sizes are fixed by the A/B buffer RAMs, so they are not overridable.
package fft_pkg;
  localparam int N = 9;
  localparam int FFT_SIZE = 2**N;
  localparam logic [N-1:0] LAST_IDX = N'(FFT_SIZE - 1);

  typedef enum logic [2:0] {IDLE, LOAD, FLUSH, START, WAIT} rd_state_t;
  typedef enum logic {BANK_A = 1'b0, BANK_B = 1'b1} bank_t;
endpackage

// File: rtl/buf_write_ctrl.sv
// Write side of the A/B buffers: address, bank steering, full flags and sticky overrun.
// Write enables are combinational from sample_valid; a full target bank drops the sample.
module buf_write_ctrl
  import fft_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         sample_valid,
  input  logic         clear_overrun,
  input  logic [1:0]   release_mask,
  output logic         buf_we_a,
  output logic         buf_we_b,
  output logic [N-1:0] wr_addr,
  output logic [1:0]   full,
  output logic         overrun
);
  bank_t        wr_bank;
  logic [N-1:0] wr_idx;
  logic         accept;
  logic         drop;
  logic [1:0]   set_mask;

  assign accept   = sample_valid & ~reset & ~full[wr_bank];
  assign drop     = sample_valid & full[wr_bank];
  assign buf_we_a = accept & (wr_bank == BANK_A);
  assign buf_we_b = accept & (wr_bank == BANK_B);
  assign wr_addr  = wr_idx;
  assign set_mask = (accept && wr_idx == LAST_IDX) ?
                    ((wr_bank == BANK_A) ? 2'b01 : 2'b10) : 2'b00;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_bank <= BANK_A;
      wr_idx  <= '0;
      full    <= 2'b00;
      overrun <= 1'b0;
    end else begin
      if (accept) begin
        wr_idx <= wr_idx + N'(1);
        if (wr_idx == LAST_IDX)
          wr_bank <= (wr_bank == BANK_A) ? BANK_B : BANK_A;
      end
      // Reader only ever releases the bank the writer is not filling.
      full <= (full & ~release_mask) | set_mask;
      if (drop)
        overrun <= 1'b1;
      else if (clear_overrun)
        overrun <= 1'b0;
    end
  end
endmodule

// File: rtl/fft_frame_sequencer.sv
// Streams each full A/B bank into the FFT core: LOAD 512 reads, one FLUSH, one fft_start.
// fft_load/fft_add_rd lag rd_addr by one cycle for the RAM read; new frames wait for fft_done.
module fft_frame_sequencer
  import fft_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_valid,
  input  logic             fft_done,
  input  logic             clear_overrun,
  output logic             buf_we_a,
  output logic             buf_we_b,
  output logic [N-1:0]     wr_addr,
  output logic [N-1:0]     rd_addr,
  output logic             rd_sel,
  output logic             fft_load,
  output logic [N-1:0]     fft_add_rd,
  output logic             fft_start,
  output logic             busy,
  output logic             overrun,
  output logic [CNT_W-1:0] frame_cnt
);
  rd_state_t    state;
  bank_t        rd_bank;
  logic [N-1:0] rd_idx;
  logic [1:0]   full;
  logic [1:0]   release_mask;

  buf_write_ctrl u_buf_write_ctrl (
    .clk           (clk),
    .reset         (reset),
    .sample_valid  (sample_valid),
    .clear_overrun (clear_overrun),
    .release_mask  (release_mask),
    .buf_we_a      (buf_we_a),
    .buf_we_b      (buf_we_b),
    .wr_addr       (wr_addr),
    .full          (full),
    .overrun       (overrun)
  );

  assign rd_addr      = rd_idx;
  assign rd_sel       = rd_bank;
  assign release_mask = (state == FLUSH) ? ((rd_bank == BANK_A) ? 2'b01 : 2'b10) : 2'b00;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rd_bank    <= BANK_A;
      rd_idx     <= '0;
      fft_load   <= 1'b0;
      fft_add_rd <= '0;
      fft_start  <= 1'b0;
      busy       <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      fft_start  <= 1'b0;
      fft_load   <= (state == LOAD);
      fft_add_rd <= rd_idx;
      case (state)
        IDLE: if (full[rd_bank]) begin
          state  <= LOAD;
          rd_idx <= '0;
          busy   <= 1'b1;
        end
        // rd_idx wraps to 0 on the last read, leaving rd_addr at 0 outside LOAD.
        LOAD: begin
          rd_idx <= rd_idx + N'(1);
          if (rd_idx == LAST_IDX)
            state <= FLUSH;
        end
        FLUSH: begin
          rd_bank   <= (rd_bank == BANK_A) ? BANK_B : BANK_A;
          fft_start <= 1'b1;
          state     <= START;
        end
        START: begin
          frame_cnt <= frame_cnt + CNT_W'(1);
          state     <= WAIT;
        end
        WAIT: if (fft_done) begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Randomized bench for fft_frame_sequencer against a frame-timing reference model.
module tb_fft_frame_sequencer;
  import fft_pkg::*;
  localparam int CNT_W = 8;
  localparam int DRAIN_LIMIT = 6000;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             sample_valid = 1'b0;
  logic             fft_done = 1'b0;
  logic             clear_overrun = 1'b0;
  logic             buf_we_a, buf_we_b, rd_sel, fft_load, fft_start, busy, overrun;
  logic [N-1:0]     wr_addr, rd_addr, fft_add_rd;
  logic [CNT_W-1:0] frame_cnt;

  fft_frame_sequencer #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .fft_done(fft_done),
    .clear_overrun(clear_overrun), .buf_we_a(buf_we_a), .buf_we_b(buf_we_b),
    .wr_addr(wr_addr), .rd_addr(rd_addr), .rd_sel(rd_sel), .fft_load(fft_load),
    .fft_add_rd(fft_add_rd), .fft_start(fft_start), .busy(busy), .overrun(overrun),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  bit abort = 0;

  // Reference model: m_k counts cycles since F (-1 = idle); 515 means waiting for fft_done.
  int       m_k = -1, m_widx = 0, m_wcnt = 0, m_cnt = 0;
  bit       m_wbank = 0, m_rbank = 0, m_ovr = 0;
  bit [1:0] m_full = 2'b00;
  int       done_dly = 199;
  bit       dly_rand = 0;
  bit       prev_rst = 0;
  int       n_we_a = 0, n_we_b = 0, n_start = 0, n_load = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      if (n_fail >= 40) abort = 1;
    end
  endtask

  task automatic run_cycle(input bit sv, input bit clr, input bit rst, input int stray);
    bit done;
    bit [1:0] set_mask, clr_mask;
    bit ovr_set;
    bit ld;
    if (m_k < 0 && m_full[m_rbank]) m_k = 0;
    done = (m_k >= 515 && done_dly >= 0 && m_wcnt >= done_dly) ||
           (m_k <= 514 && stray > 0 && $urandom_range(0, 99) < stray);
    sample_valid = sv; clear_overrun = clr; reset = rst; fft_done = done;
    @(negedge clk);
    check("we_a", buf_we_a, sv && !rst && !m_wbank && !m_full[0]);
    check("we_b", buf_we_b, sv && !rst && m_wbank && !m_full[1]);
    if (!(rst && !prev_rst)) begin
      ld = (m_k >= 2 && m_k <= 513);
      check("wr_addr", wr_addr, m_widx);
      check("rd_addr", rd_addr, (m_k >= 1 && m_k <= 512) ? m_k - 1 : 0);
      check("rd_sel", rd_sel, m_rbank);
      check("fft_load", fft_load, ld);
      check("fft_add_rd", fft_add_rd, ld ? m_k - 2 : 0);
      check("fft_start", fft_start, m_k == 514);
      check("busy", busy, m_k >= 1);
      check("overrun", overrun, m_ovr);
      check("frame_cnt", frame_cnt, m_cnt);
    end
    if (buf_we_a === 1'b1) n_we_a++;
    if (buf_we_b === 1'b1) n_we_b++;
    if (fft_start === 1'b1) n_start++;
    if (fft_load === 1'b1) n_load++;
    if (rst) begin
      m_k = -1; m_widx = 0; m_wcnt = 0; m_cnt = 0;
      m_wbank = 0; m_rbank = 0; m_ovr = 0; m_full = 2'b00;
    end else begin
      set_mask = 2'b00; clr_mask = 2'b00; ovr_set = 0;
      if (sv) begin
        if (m_full[m_wbank]) ovr_set = 1;
        else if (m_widx == FFT_SIZE - 1) begin
          set_mask[m_wbank] = 1'b1; m_wbank = !m_wbank; m_widx = 0;
        end else m_widx++;
      end
      if (m_k >= 0 && m_k < 515) begin
        if (m_k == 513) begin clr_mask[m_rbank] = 1'b1; m_rbank = !m_rbank; end
        if (m_k == 514) begin
          m_cnt = (m_cnt + 1) % (1 << CNT_W);
          m_wcnt = 0;
          if (dly_rand) done_dly = $urandom_range(0, 900);
        end
        m_k++;
      end else if (m_k == 515) begin
        if (done) m_k = -1; else m_wcnt++;
      end
      m_full = (m_full & ~clr_mask) | set_mask;
      if (ovr_set) m_ovr = 1; else if (clr) m_ovr = 0;
    end
    prev_rst = rst;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    run_cycle(1'b0, 1'b0, 1'b1, 0);
    run_cycle(1'b0, 1'b0, 1'b1, 0);
    n_we_a = 0; n_we_b = 0; n_start = 0; n_load = 0;
  endtask

  task automatic run_samples(input int n, input int gmin, input int gmax,
                             input int stray, input int clr_pct, input bit clr_last);
    int sent = 0;
    int gap = 0;
    while (sent < n && !abort) begin
      if (gap == 0) begin
        sent++;
        run_cycle(1'b1, (clr_last && sent == n) || ($urandom_range(0, 99) < clr_pct), 1'b0, stray);
        gap = $urandom_range(gmin, gmax);
      end else begin
        run_cycle(1'b0, $urandom_range(0, 99) < clr_pct, 1'b0, stray);
        gap--;
      end
    end
  endtask

  task automatic drain(input int stray);
    int guard = 0;
    while (!(m_k < 0 && m_full == 2'b00) && guard < DRAIN_LIMIT && !abort) begin
      run_cycle(1'b0, 1'b0, 1'b0, stray);
      guard++;
    end
    if (guard >= DRAIN_LIMIT) check("drain_timeout", guard, DRAIN_LIMIT - 1);
    run_cycle(1'b0, 1'b0, 1'b0, 0);
    run_cycle(1'b0, 1'b0, 1'b0, 0);
  endtask

  initial begin
    int guard;
    // One frame, samples spaced 4 cycles, fft_done 200 cycles after fft_start.
    do_reset();
    done_dly = 199;
    run_samples(512, 3, 3, 0, 0, 0);
    drain(0);
    check("p1_we_a", n_we_a, 512);
    check("p1_we_b", n_we_b, 0);
    check("p1_loads", n_load, 512);
    check("p1_starts", n_start, 1);
    check("p1_frame_cnt", frame_cnt, 1);
    check("p1_busy", busy, 0);

    // Two back-to-back frames.
    if (!abort) begin
      do_reset();
      run_samples(1024, 0, 0, 0, 0, 0);
      drain(0);
      check("p2_we_a", n_we_a, 512);
      check("p2_we_b", n_we_b, 512);
      check("p2_loads", n_load, 1024);
      check("p2_frame_cnt", frame_cnt, 2);
    end

    // fft_done withheld: A refilled, B full, tail samples dropped; clear races a drop.
    if (!abort) begin
      do_reset();
      done_dly = -1;
      run_samples(1600, 1, 1, 0, 0, 1);
      check("p3_ovr_set_wins", overrun, 1);
      check("p3_we_a", n_we_a, 1024);
      check("p3_we_b", n_we_b, 512);
      check("p3_starts", n_start, 1);
      run_cycle(1'b0, 1'b1, 1'b0, 0);
      check("p3_ovr_clr", overrun, 0);
      done_dly = 20;
      drain(0);
      check("p3_frame_cnt", frame_cnt, 3);
    end

    // Reset in the middle of LOAD, then a fresh frame.
    if (!abort) begin
      do_reset();
      done_dly = 199;
      run_samples(512, 0, 0, 0, 0, 0);
      guard = 0;
      while (m_k != 202 && guard < 2000) begin
        run_cycle(1'b0, 1'b0, 1'b0, 0);
        guard++;
      end
      check("p4_add_rd_200", fft_add_rd, 200);
      run_cycle(1'b0, 1'b0, 1'b1, 0);
      check("p4_rst_addr", {wr_addr, rd_addr, fft_add_rd}, 0);
      check("p4_rst_flags", {buf_we_a, buf_we_b, rd_sel, fft_load, fft_start, busy, overrun, frame_cnt}, 0);
      n_we_a = 0; n_we_b = 0; n_start = 0; n_load = 0;
      run_samples(512, 0, 0, 0, 0, 0);
      drain(0);
      check("p4_we_a", n_we_a, 512);
      check("p4_we_b", n_we_b, 0);
      check("p4_starts", n_start, 1);
    end

    // Random traffic, random fft_done latency, stray fft_done pulses, random clears.
    if (!abort) begin
      do_reset();
      dly_rand = 1;
      done_dly = $urandom_range(0, 900);
      run_samples(3000, 0, 2, 3, 2, 0);
      drain(0);
      check("p5_starts", n_start, m_cnt);
      check("p5_frame_cnt", frame_cnt, m_cnt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
